// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - BIP2 multi-cycle control FSM (FETCH/DECODE/EXECUTE/HALT)
// Optional conditional branches enabled by macro CU_BRANCH_EN.
module bip_control_unit #(
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    cu_reset,
    input  logic [OPCODE_WIDTH-1:0] ir_opcode,
    input  logic                    acc_zero,
    input  logic                    acc_neg,
    output logic                    ir_wr,
    output logic                    pc_wr,
    output logic                    acc_wr,
    output logic                    mem_wr,
    output logic                    pc_src,
    output logic [1:0]              acc_src,
    output logic                    alu_op,
    output logic                    alu_src_b,
    output logic [1:0]              cu_state,
    output logic                    cu_halted
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_DECODE  = 2'b01,
        S_EXECUTE = 2'b10,
        S_HALT    = 2'b11
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(5'b00000);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(5'b00001);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(5'b00010);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(5'b00011);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(5'b00100);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5'b00101);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(5'b00110);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(5'b00111);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(5'b01110);

    state_t state_q, state_d;
    logic   branch_taken;

    always_ff @(posedge clock) begin
        if (cu_reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = (ir_opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            S_EXECUTE: state_d = S_FETCH;
            default:   state_d = S_HALT;
        endcase
    end

`ifdef CU_BRANCH_EN
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = OPCODE_WIDTH'(5'b01000);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE = OPCODE_WIDTH'(5'b01001);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGT = OPCODE_WIDTH'(5'b01010);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGE = OPCODE_WIDTH'(5'b01011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLT = OPCODE_WIDTH'(5'b01100);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLE = OPCODE_WIDTH'(5'b01101);

    always_comb begin
        branch_taken = 1'b0;
        case (ir_opcode)
            OP_BEQ:  branch_taken = acc_zero;
            OP_BNE:  branch_taken = !acc_zero;
            OP_BGT:  branch_taken = !acc_zero && !acc_neg;
            OP_BGE:  branch_taken = !acc_neg;
            OP_BLT:  branch_taken = acc_neg;
            OP_BLE:  branch_taken = acc_neg || acc_zero;
            default: branch_taken = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = acc_zero | acc_neg;
    assign branch_taken = 1'b0;
`endif

    // Strobes are gated by cu_reset so a reset mid-instruction never commits EXECUTE.
    always_comb begin
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        acc_wr    = 1'b0;
        mem_wr    = 1'b0;
        pc_src    = 1'b0;
        acc_src   = 2'b00;
        alu_op    = 1'b0;
        alu_src_b = 1'b0;
        if (!cu_reset) begin
            if (state_q == S_FETCH) begin
                ir_wr = 1'b1;
            end
            if (state_q == S_EXECUTE) begin
                pc_wr  = 1'b1;
                pc_src = (ir_opcode == OP_JMP) || branch_taken;
                case (ir_opcode)
                    OP_STO: mem_wr = 1'b1;
                    OP_LD: begin
                        acc_wr  = 1'b1;
                        acc_src = 2'b01;
                    end
                    OP_LDI: begin
                        acc_wr  = 1'b1;
                        acc_src = 2'b10;
                    end
                    OP_ADD: acc_wr = 1'b1;
                    OP_ADDI: begin
                        acc_wr    = 1'b1;
                        alu_src_b = 1'b1;
                    end
                    OP_SUB: begin
                        acc_wr = 1'b1;
                        alu_op = 1'b1;
                    end
                    OP_SUBI: begin
                        acc_wr    = 1'b1;
                        alu_op    = 1'b1;
                        alu_src_b = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cu_state  = state_q;
    assign cu_halted = (state_q == S_HALT);

endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - randomized self-checking bench for bip_control_unit
// Honours CU_BRANCH_EN the same way as the design build.
module tb_bip_control_unit;

    logic       clock;
    logic       cu_reset;
    logic [4:0] ir_opcode;
    logic       acc_zero;
    logic       acc_neg;
    logic       ir_wr, pc_wr, acc_wr, mem_wr, pc_src, alu_op, alu_src_b, cu_halted;
    logic [1:0] acc_src, cu_state;

`ifdef CU_BRANCH_EN
    localparam int BR = 1;
`else
    localparam int BR = 0;
`endif

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 0;

    // Reference: step index within the current instruction, and whether HLT parked us
    int m_phase  = 0;
    bit m_halted = 0;
    bit m_valid  = 0;

    bip_control_unit #(.OPCODE_WIDTH(5)) dut (
        .clock     (clock),
        .cu_reset  (cu_reset),
        .ir_opcode (ir_opcode),
        .acc_zero  (acc_zero),
        .acc_neg   (acc_neg),
        .ir_wr     (ir_wr),
        .pc_wr     (pc_wr),
        .acc_wr    (acc_wr),
        .mem_wr    (mem_wr),
        .pc_src    (pc_src),
        .acc_src   (acc_src),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b),
        .cu_state  (cu_state),
        .cu_halted (cu_halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [11:0] expect_outs(input bit rst, input int ph, input bit hlt,
                                                input logic [4:0] op, input bit z, input bit n);
        logic       irw, pcw, accw, memw, pcs, aop, asb;
        logic [1:0] asrc, st;
        irw = 0; pcw = 0; accw = 0; memw = 0; pcs = 0; aop = 0; asb = 0; asrc = 0;
        st = hlt ? 2'd3 : 2'(ph);
        if (!rst && !hlt && ph == 0) irw = 1;
        if (!rst && !hlt && ph == 2) begin
            pcw = 1;
            case (int'(op))
                1:  memw = 1;
                2:  begin accw = 1; asrc = 2'd1; end
                3:  begin accw = 1; asrc = 2'd2; end
                4:  begin accw = 1; end
                5:  begin accw = 1; asb = 1; end
                6:  begin accw = 1; aop = 1; end
                7:  begin accw = 1; aop = 1; asb = 1; end
                14: pcs = 1;
`ifdef CU_BRANCH_EN
                8:  pcs = z;
                9:  pcs = !z;
                10: pcs = !z && !n;
                11: pcs = !n;
                12: pcs = n;
                13: pcs = n || z;
`endif
                default: ;
            endcase
        end
        return {irw, pcw, accw, memw, pcs, asrc, aop, asb, st, hlt};
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            if (cu_reset) begin
                m_phase  = 0;
                m_halted = 0;
                m_valid  = 1;
            end else if (!m_halted) begin
                if (m_phase == 1 && ir_opcode == 5'd0) m_halted = 1;
                else m_phase = (m_phase + 1) % 3;
            end
        end
    end

    initial begin
        logic [11:0] got, exp;
        forever begin
            @(negedge clock);
            if (chk_en && m_valid) begin
                got = {ir_wr, pc_wr, acc_wr, mem_wr, pc_src, acc_src, alu_op, alu_src_b,
                       cu_state, cu_halted};
                exp = expect_outs(cu_reset, m_phase, m_halted, ir_opcode, acc_zero, acc_neg);
                vectors++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL outputs @%0t op=%0d rst=%0b: got %03h expected %03h",
                             $time, ir_opcode, cu_reset, got, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input bit r, input logic [4:0] op, input bit z, input bit n);
        @(posedge clock);
        #1;
        cu_reset  = r;
        ir_opcode = op;
        acc_zero  = z;
        acc_neg   = n;
    endtask

    task automatic instr(input logic [4:0] op, input bit z, input bit n);
        repeat (3) cyc(0, op, z, n);
        #4;
    endtask

    initial begin
        bit rst;
        logic [4:0] op;
        cu_reset = 1; ir_opcode = 5'd3; acc_zero = 0; acc_neg = 0;

        cyc(1, 5'd3, 0, 0);
        chk_en = 1;
        #4;
        chk("rst_state", cu_state, 0); chk("rst_ir_wr", ir_wr, 0); chk("rst_pc_wr", pc_wr, 0);
        chk("rst_acc_wr", acc_wr, 0); chk("rst_mem_wr", mem_wr, 0);
        cyc(1, 5'd3, 0, 0); #4;
        chk("rst2_ir_wr", ir_wr, 0);

        cyc(0, 5'd3, 0, 0); #4;
        chk("ldi_c0_state", cu_state, 0); chk("ldi_c0_ir_wr", ir_wr, 1);
        cyc(0, 5'd3, 0, 0); #4;
        chk("ldi_c1_state", cu_state, 1); chk("ldi_c1_ir_wr", ir_wr, 0);
        chk("ldi_c1_pc_wr", pc_wr, 0); chk("ldi_c1_acc_wr", acc_wr, 0);
        cyc(0, 5'd3, 0, 0); #4;
        chk("ldi_c2_state", cu_state, 2); chk("ldi_acc_wr", acc_wr, 1); chk("ldi_acc_src", acc_src, 2);
        chk("ldi_pc_wr", pc_wr, 1); chk("ldi_pc_src", pc_src, 0);

        cyc(0, 5'd6, 0, 0); #4;
        chk("ldi_c3_state", cu_state, 0); chk("ldi_c3_ir_wr", ir_wr, 1);
        cyc(0, 5'd6, 0, 0); cyc(0, 5'd6, 0, 0); #4;
        chk("sub_acc_wr", acc_wr, 1); chk("sub_alu_op", alu_op, 1);
        chk("sub_alu_src_b", alu_src_b, 0); chk("sub_mem_wr", mem_wr, 0);

        instr(5'd1, 0, 0);
        chk("sto_mem_wr", mem_wr, 1); chk("sto_acc_wr", acc_wr, 0); chk("sto_pc_wr", pc_wr, 1);

        cyc(0, 5'd0, 0, 0); cyc(0, 5'd0, 0, 0); #4;
        chk("hlt_dec_state", cu_state, 1); chk("hlt_dec_pc_wr", pc_wr, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 5'd0, 0, 0); #4;
            chk("hlt_halted", cu_halted, 1); chk("hlt_state", cu_state, 3); chk("hlt_pc_wr", pc_wr, 0);
        end
        cyc(1, 5'd8, 1, 0); #4;
        chk("hlt_rst_ir_wr", ir_wr, 0);
        cyc(0, 5'd8, 1, 0); #4;
        chk("hlt_exit_state", cu_state, 0); chk("hlt_exit_ir_wr", ir_wr, 1);
        cyc(0, 5'd8, 1, 0); cyc(0, 5'd8, 1, 0); #4;
        chk("beq_z1_pc_src", pc_src, BR); chk("beq_pc_wr", pc_wr, 1); chk("beq_acc_wr", acc_wr, 0);
        instr(5'd8, 0, 0);
        chk("beq_z0_pc_src", pc_src, 0);
        instr(5'd12, 0, 1);
        chk("blt_n1_pc_src", pc_src, BR);
        instr(5'd14, 0, 0);
        chk("jmp_pc_src", pc_src, 1);

        cyc(0, 5'd4, 0, 0); cyc(0, 5'd4, 0, 0); cyc(1, 5'd4, 0, 0); #4;
        chk("abort_state", cu_state, 2); chk("abort_acc_wr", acc_wr, 0); chk("abort_pc_wr", pc_wr, 0);
        cyc(0, 5'd21, 0, 0); #4;
        chk("abort_next_state", cu_state, 0); chk("abort_next_ir_wr", ir_wr, 1);
        cyc(0, 5'd21, 1, 1); cyc(0, 5'd21, 1, 1); #4;
        chk("nop_pc_wr", pc_wr, 1); chk("nop_pc_src", pc_src, 0); chk("nop_acc_wr", acc_wr, 0);
        chk("nop_mem_wr", mem_wr, 0); chk("nop_ir_wr", ir_wr, 0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 5) == 0);
            op  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cyc(rst, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(posedge clock); #4;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
